// File: rtl/song_sequencer.sv
// Song sequencer: replays a 16-entry note memory into the multi-note player
// over a val/rdy request interface, once or in a loop.
//
// state  | meaning
// IDLE   | waiting for start; note memory writable
// ISSUE  | presenting mem[note_idx] to the player until accepted
// FINISH | one-cycle done pulse after a non-looping song
module song_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic [4:0] song_len,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  output logic       play_note_val,
  input  logic       play_note_rdy,
  output logic [2:0] play_note_num,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] idx_n;
  logic [4:0] len_r, len_n;
  logic       loop_r, loop_n;
  logic [4:0] len_clamp;
  logic       last_entry;
  logic [2:0] mem [DEPTH];

  assign len_clamp  = (song_len > 5'd16) ? 5'd16 : song_len;
  assign last_entry = ({1'b0, note_idx} == (len_r - 5'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note_idx <= 4'd0;
      len_r    <= 5'd0;
      loop_r   <= 1'b0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      len_r    <= len_n;
      loop_r   <= loop_n;
    end
  end

  // Memory is only writable while idle so the song cannot change under playback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'd0;
    end else if (wr_en && (state == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign play_note_num = mem[note_idx];
  assign busy          = (state != IDLE);

  always_comb begin
    state_n       = state;
    idx_n         = note_idx;
    len_n         = len_r;
    loop_n        = loop_r;
    play_note_val = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (len_clamp != 5'd0) begin
            len_n   = len_clamp;
            loop_n  = loop;
            idx_n   = 4'd0;
            state_n = ISSUE;
          end else begin
            state_n = FINISH;
          end
        end
      end
      ISSUE: begin
        play_note_val = 1'b1;
        if (play_note_rdy) begin
          if (!last_entry) begin
            idx_n = note_idx + 4'd1;
          end else if (loop_r) begin
            idx_n = 4'd0;
          end else begin
            state_n = FINISH;
          end
        end
        // A coinciding transfer still reached the player; we just abandon the rest.
        if (stop) begin
          state_n = IDLE;
          idx_n   = 4'd0;
        end
      end
      FINISH: begin
        done    = !stop;
        state_n = IDLE;
        idx_n   = 4'd0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a simple fixed-duration player model
// and a transfer/done logger timed relative to the accepted start edge.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic [4:0] song_len;
  logic       loop;
  logic       start;
  logic       stop;
  logic       play_note_val;
  logic       play_note_rdy;
  logic [2:0] play_note_num;
  logic       busy;
  logic [3:0] note_idx;
  logic       done;

  int checks = 0;
  int errors = 0;

  song_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .song_len(song_len), .loop(loop), .start(start), .stop(stop),
    .play_note_val(play_note_val), .play_note_rdy(play_note_rdy),
    .play_note_num(play_note_num), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  // player model: after accepting a note it is unavailable for dur cycles
  int   dur = 4;
  int   pcnt = 0;
  logic force_low = 1'b0;
  assign play_note_rdy = (pcnt == 0) && !force_low;

  always @(posedge clk) begin
    if (rst) pcnt <= 0;
    else if (play_note_val && play_note_rdy) pcnt <= dur;
    else if (pcnt > 0) pcnt <= pcnt - 1;
  end

  int ecnt = 0;
  int base = 0;
  int t_cyc[$];
  int t_num[$];
  int t_idx[$];
  int done_cnt = 0;
  int done_cyc = -1;

  always @(posedge clk) begin
    if (!rst && play_note_val && play_note_rdy) begin
      t_cyc.push_back(ecnt - base);
      t_num.push_back(int'(play_note_num));
      t_idx.push_back(int'(note_idx));
    end
    if (!rst && done) begin
      done_cnt = done_cnt + 1;
      done_cyc = ecnt - base;
    end
    ecnt = ecnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 3'(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (the cycle after start is sampled).
  task automatic go(input int len, input logic lp);
    t_cyc.delete(); t_num.delete(); t_idx.delete();
    done_cnt = 0; done_cyc = -1;
    song_len = 5'(len); loop = lp; start = 1'b1;
    base = ecnt;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) return;
      tick(1);
    end
    if (done_cnt == d0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (t_cyc.size() >= n) return;
      tick(1);
    end
    if (t_cyc.size() < n) chk({tag, "_timeout"}, t_cyc.size(), n);
  endtask

  initial begin
    int n0, i0, orv;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    song_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_val", play_note_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_num", play_note_num, 0);

    // single pass, player duration 4
    wr(0, 1); wr(1, 2); wr(2, 3);
    dur = 4;
    go(3, 1'b0);
    chk("p1_val_rise", play_note_val, 1);
    wait_done("p1", 60);
    chk("p1_nxfer", t_cyc.size(), 3);
    if (t_cyc.size() == 3) begin
      chk("p1_c0", t_cyc[0], 1);  chk("p1_c1", t_cyc[1], 6);  chk("p1_c2", t_cyc[2], 11);
      chk("p1_n0", t_num[0], 1);  chk("p1_n1", t_num[1], 2);  chk("p1_n2", t_num[2], 3);
    end
    chk("p1_done_cyc", done_cyc, 12);
    chk("p1_busy_fall", busy, 0);
    chk("p1_idx_clr", note_idx, 0);
    tick(6);

    // looping pass, stopped at cycle 18
    go(3, 1'b1);
    wait_xfers("p2", 4, 60);
    if (t_cyc.size() >= 4) begin
      chk("p2_c3", t_cyc[3], 16);
      chk("p2_n3", t_num[3], 1);
      chk("p2_i3", t_idx[3], 0);
    end
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("p2_stop_busy", busy, 0);
    chk("p2_stop_val", play_note_val, 0);
    chk("p2_stop_idx", note_idx, 0);
    tick(6);
    chk("p2_no_done", done_cnt, 0);

    // rdy held low: request must hold
    force_low = 1'b1;
    go(3, 1'b0);
    n0 = play_note_num; i0 = note_idx;
    tick(10);
    chk("p3_val_hold", play_note_val, 1);
    chk("p3_num_hold", play_note_num, n0);
    chk("p3_idx_hold", note_idx, i0);
    chk("p3_no_xfer", t_cyc.size(), 0);
    force_low = 1'b0;
    wait_done("p3", 60);
    chk("p3_nxfer", t_cyc.size(), 3);
    tick(6);

    // zero-length song
    go(0, 1'b0);
    chk("p4_done", done, 1);
    chk("p4_busy", busy, 1);
    chk("p4_val", play_note_val, 0);
    tick(1);
    chk("p4_busy_fall", busy, 0);
    chk("p4_done_fall", done, 0);
    chk("p4_nxfer", t_cyc.size(), 0);

    // clamp to 16, write and start while busy ignored
    dur = 0;
    go(20, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'd7;
    song_len = 5'd1; start = 1'b1;
    tick(1);
    wr_en = 1'b0; start = 1'b0;
    wait_done("p5", 60);
    chk("p5_nxfer", t_cyc.size(), 16);
    if (t_cyc.size() == 16) begin
      chk("p5_last_idx", t_idx[15], 15);
      chk("p5_last_cyc", t_cyc[15], 16);
    end
    chk("p5_done_cyc", done_cyc, 17);
    tick(2);
    go(1, 1'b0);
    wait_done("p5b", 20);
    chk("p5b_nxfer", t_cyc.size(), 1);
    if (t_cyc.size() == 1) chk("p5b_mem0_kept", t_num[0], 1);
    tick(2);

    // reset mid-playback
    dur = 4;
    go(3, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("p6_val", play_note_val, 0);
    chk("p6_busy", busy, 0);
    chk("p6_done", done, 0);
    chk("p6_idx", note_idx, 0);
    chk("p6_num", play_note_num, 0);
    dur = 0;
    go(1, 1'b0);
    wait_done("p6b", 20);
    chk("p6b_nxfer", t_cyc.size(), 1);
    if (t_cyc.size() == 1) chk("p6b_num", t_num[0], 0);
    tick(2);
    go(16, 1'b0);
    wait_done("p6c", 40);
    chk("p6c_nxfer", t_cyc.size(), 16);
    orv = 0;
    foreach (t_num[k]) orv = orv | t_num[k];
    chk("p6c_mem_clear", orv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a short stored song by sequencing the multi-note player.
- Holds a 16-entry note memory, loaded through a write port. Each entry is a 3-bit note number; 0 = rest/silence.
- On start, walks the memory from index 0 and issues one play request per entry over the player's val/rdy interface. Optionally loops.
- Sits between the top-level control logic (switches/buttons) and the multi-note player.

Parameters:
- DEPTH, 16, number of song entries. Fixed at 16; address and index widths are 4 bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- wr_en  input  1  write strobe into note memory
- wr_addr  input  4  write address
- wr_data  input  3  note number written (0 = rest, 1..7 = note)
- song_len  input  5  number of entries to play; sampled on accepted start; 0..16, values >16 clamp to 16
- loop  input  1  sampled on accepted start; 1 = repeat from entry 0 after last entry
- start  input  1  level/pulse; accepted only in IDLE
- stop  input  1  abort playback
- play_note_val  output  1  request to player
- play_note_rdy  input  1  player ready
- play_note_num  output  3  note number presented with val
- busy  output  1  high in any state other than IDLE
- note_idx  output  4  index of the entry currently presented
- done  output  1  one-cycle pulse when a non-looping song completes

Behaviour:
- Interface: clock is clk; reset is synchronous and active-high on rst. All state updates on the rising clk edge.
- Reset:
  - State = IDLE; note_idx = 0; len and loop registers = 0.
  - All 16 memory entries cleared to 0.
  - Outputs: play_note_val = 0, busy = 0, done = 0, play_note_num = mem[0] = 0.
  - Reset mid-playback aborts immediately; no done pulse is generated.
- Memory:
  - Write occurs at the edge when wr_en = 1 and state = IDLE. Writes while busy are ignored.
  - Read is combinational: play_note_num = mem[note_idx].
- States: IDLE, ISSUE, FINISH.
- IDLE:
  - val = 0.
  - start = 1 with clamped song_len != 0: latch len and loop, set note_idx = 0, go to ISSUE. play_note_val rises the cycle after start.
  - start = 1 with song_len = 0: go to FINISH. No request is issued.
  - Otherwise stay in IDLE.
- ISSUE:
  - play_note_val = 1; play_note_num is held stable until transfer.
  - Transfer occurs on a cycle where val and rdy are both 1.
  - On transfer, if note_idx != len-1: note_idx + 1, stay in ISSUE.
  - On transfer, if note_idx == len-1 and loop = 1: note_idx = 0, stay in ISSUE.
  - On transfer, if note_idx == len-1 and loop = 0: go to FINISH.
  - No transfer: hold all state.
- FINISH: done = 1 for exactly one cycle, val = 0, then go to IDLE with note_idx = 0.
- stop:
  - In ISSUE or FINISH, stop forces IDLE at the next edge, with note_idx = 0 and no done pulse.
  - If stop and a transfer coincide, the transfer counts: the player has accepted that note. The sequencer still goes to IDLE.
  - stop in IDLE has no effect. stop has priority over start in the same cycle.
- Rest entries (0) are issued like any other note. The player outputs silence for that duration.
- Throughput: one transfer per cycle if rdy stays high. With the player, the rate is bounded by its note duration.
- start while busy is ignored. loop and song_len changes during playback are ignored.
- busy = (state != IDLE).

Test Plan:
- Load mem[0..2] = 1, 2, 3; song_len = 3; loop = 0; start for 1 cycle, with the player model note_duration = 4.
  -> val rises next cycle; transfers at cycles 1, 6, 11 with nums 1, 2, 3; done pulses at cycle 12; busy falls at cycle 13.
- Same song with loop = 1.
  -> the 4th transfer is num 1 at idx 0 (cycle 16); done never pulses.
  -> stop at cycle 18 makes busy = 0 and val = 0 from cycle 19.
- rdy held low for 10 cycles while in ISSUE.
  -> val stays 1; num and note_idx stay constant; no advance.
- song_len = 0 with start.
  -> no val ever; done = 1 on the cycle after start; busy = 1 for exactly 1 cycle.
- wr_en to mem[0] = 7 while busy, then a second song run.
  -> write ignored; mem[0] still the previously loaded value.
  -> start while busy is ignored; song_len = 20 plays 16 entries.
- rst asserted mid-ISSUE.
  -> next cycle: val = 0, busy = 0, done = 0, note_idx = 0, all memory reads 0.
  -> a following start with song_len = 1 issues num 0.
